fetch_stage: RTL and testbench

- Instruction-fetch stage of the 16-bit pipelined CPU; owns the PC and the IF/ID pipeline register.
- Issues requests to a variable-latency instruction memory and buffers one returned word while decode stalls.
- Drives the instruction word and PC+2 into the decode stage.
- Accepts branch/jump redirects, flushes and halt from decode.

---
 rtl/fetch_stage.sv | 164 ++++++++++++++++
 tb/tb_fetch_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, the IF/ID register and a one-word hold buffer.
// Optional performance counters are enabled with `define FETCH_PERF_CNT_EN.
module fetch_stage #(
   parameter logic [15:0] RESET_PC    = 16'h0000,
   parameter logic [15:0] NOP_INSTR   = 16'h0000,
   parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_ready,
   input  logic [15:0] imem_rdata,
   output logic [15:0] if_id_instr,
   output logic [15:0] if_id_next_pc,
   output logic        if_id_valid,
   output logic        halted
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] fetch_count,
   output logic [31:0] stall_cycles
`endif
);

   typedef enum logic [1:0] {FETCH, HOLD, DRAIN, HALTED} state_e;

   state_e      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] drain_addr_q, drain_addr_d;
   logic [15:0] instr_q, instr_d;
   logic [15:0] npc_q, npc_d;
   logic        valid_q, valid_d;
   logic [15:0] hold_instr_q, hold_instr_d;
   logic [15:0] hold_npc_q, hold_npc_d;
   logic [15:0] pc_inc;

   assign pc_inc = pc_q + 16'd2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= FETCH;
         pc_q         <= RESET_PC;
         drain_addr_q <= RESET_PC;
         instr_q      <= NOP_INSTR;
         npc_q        <= '0;
         valid_q      <= 1'b0;
         hold_instr_q <= '0;
         hold_npc_q   <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         drain_addr_q <= drain_addr_d;
         instr_q      <= instr_d;
         npc_q        <= npc_d;
         valid_q      <= valid_d;
         hold_instr_q <= hold_instr_d;
         hold_npc_q   <= hold_npc_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      drain_addr_d = drain_addr_q;
      instr_d      = instr_q;
      npc_d        = npc_q;
      valid_d      = valid_q;
      hold_instr_d = hold_instr_q;
      hold_npc_d   = hold_npc_q;

      if (redirect) begin
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
         pc_d    = redirect_pc & 16'hFFFE;
         unique case (state_q)
            FETCH: begin
               // An unanswered request cannot be aborted; keep presenting it until ready.
               if (imem_ready) begin
                  state_d = FETCH;
               end else begin
                  state_d      = DRAIN;
                  drain_addr_d = pc_q;
               end
            end
            DRAIN:   state_d = imem_ready ? FETCH : DRAIN;
            default: state_d = FETCH;
         endcase
      end else begin
         unique case (state_q)
            FETCH: begin
               if (imem_ready) begin
                  pc_d = pc_inc;
                  if (stall) begin
                     hold_instr_d = imem_rdata;
                     hold_npc_d   = pc_inc;
                     state_d      = HOLD;
                  end else begin
                     instr_d = imem_rdata;
                     npc_d   = pc_inc;
                     valid_d = 1'b1;
                     if (imem_rdata[15:12] == HALT_OPCODE) state_d = HALTED;
                  end
               end else if (!stall) begin
                  instr_d = NOP_INSTR;
                  valid_d = 1'b0;
               end
            end
            HOLD: begin
               if (!stall) begin
                  instr_d = hold_instr_q;
                  npc_d   = hold_npc_q;
                  valid_d = 1'b1;
                  state_d = (hold_instr_q[15:12] == HALT_OPCODE) ? HALTED : FETCH;
               end
            end
            DRAIN: begin
               if (!stall) begin
                  instr_d = NOP_INSTR;
                  valid_d = 1'b0;
               end
               if (imem_ready) state_d = FETCH;
            end
            default: begin
               if (!stall) begin
                  instr_d = NOP_INSTR;
                  valid_d = 1'b0;
               end
            end
         endcase
      end
   end

   assign imem_req      = ~rst & ((state_q == FETCH) | (state_q == DRAIN));
   assign imem_addr     = (state_q == DRAIN) ? drain_addr_q : pc_q;
   assign if_id_instr   = instr_q;
   assign if_id_next_pc = npc_q;
   assign if_id_valid   = valid_q;
   assign halted        = (state_q == HALTED);

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count_q, stall_cycles_q;
   logic        load_valid;

   assign load_valid = ~redirect & ~stall &
                       (((state_q == FETCH) & imem_ready) | (state_q == HOLD));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_count_q  <= '0;
         stall_cycles_q <= '0;
      end else begin
         if (load_valid && (fetch_count_q != '1)) fetch_count_q <= fetch_count_q + 32'd1;
         if (stall && valid_q && (stall_cycles_q != '1)) stall_cycles_q <= stall_cycles_q + 32'd1;
      end
   end

   assign fetch_count  = fetch_count_q;
   assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage: reset, latency, stall/hold, redirect, halt, wrap.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ready;
   logic [15:0] imem_rdata;
   logic [15:0] if_id_instr;
   logic [15:0] if_id_next_pc;
   logic        if_id_valid;
   logic        halted;

   int checks = 0;
   int errors = 0;

   fetch_stage #(
      .RESET_PC   (16'h0000),
      .NOP_INSTR  (16'h0000),
      .HALT_OPCODE(4'hF)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ready   (imem_ready),
      .imem_rdata   (imem_rdata),
      .if_id_instr  (if_id_instr),
      .if_id_next_pc(if_id_next_pc),
      .if_id_valid  (if_id_valid),
      .halted       (halted)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
      imem_ready = 1'b0; imem_rdata = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      rst = 1'b1;
      #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", imem_req); end
      checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL rst_addr: got %h want 0000", imem_addr); end
      checks++; if ({if_id_instr, if_id_next_pc, if_id_valid} !== {16'h0000, 16'h0000, 1'b0})
         begin errors++; $display("FAIL rst_ifid: got %h/%h/%b want 0000/0000/0", if_id_instr, if_id_next_pc, if_id_valid); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b want 0", halted); end
      rst = 1'b0;
      #1;
      checks++; if ({imem_req, imem_addr} !== {1'b1, 16'h0000})
         begin errors++; $display("FAIL rst_first_req: got %b/%h want 1/0000", imem_req, imem_addr); end
   endtask

   task automatic test_single_cycle();
      do_reset();
      imem_ready = 1'b1; imem_rdata = 16'h1234;
      tick();
      checks++; if ({if_id_instr, if_id_next_pc, if_id_valid} !== {16'h1234, 16'h0002, 1'b1})
         begin errors++; $display("FAIL sc_ifid1: got %h/%h/%b want 1234/0002/1", if_id_instr, if_id_next_pc, if_id_valid); end
      checks++; if ({imem_req, imem_addr} !== {1'b1, 16'h0002})
         begin errors++; $display("FAIL sc_addr1: got %b/%h want 1/0002", imem_req, imem_addr); end
      tick();
      checks++; if ({if_id_instr, if_id_next_pc, if_id_valid} !== {16'h1234, 16'h0004, 1'b1})
         begin errors++; $display("FAIL sc_ifid2: got %h/%h/%b want 1234/0004/1", if_id_instr, if_id_next_pc, if_id_valid); end
      checks++; if (imem_addr !== 16'h0004) begin errors++; $display("FAIL sc_addr2: got %h want 0004", imem_addr); end
   endtask

   task automatic test_latency();
      do_reset();
      imem_ready = 1'b1; imem_rdata = 16'h1111;
      tick();
      imem_ready = 1'b0; imem_rdata = 16'hBAD0;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++; if ({if_id_instr, if_id_valid} !== {16'h0000, 1'b0})
            begin errors++; $display("FAIL lat_bubble%0d: got %h/%b want 0000/0", i, if_id_instr, if_id_valid); end
         checks++; if ({imem_req, imem_addr} !== {1'b1, 16'h0002})
            begin errors++; $display("FAIL lat_addr%0d: got %b/%h want 1/0002", i, imem_req, imem_addr); end
      end
      imem_ready = 1'b1; imem_rdata = 16'h2222;
      tick();
      checks++; if ({if_id_instr, if_id_next_pc, if_id_valid} !== {16'h2222, 16'h0004, 1'b1})
         begin errors++; $display("FAIL lat_word: got %h/%h/%b want 2222/0004/1", if_id_instr, if_id_next_pc, if_id_valid); end
   endtask

   task automatic test_stall_hold();
      do_reset();
      // redirect with ready: data discarded, odd target bit ignored
      imem_ready = 1'b1; imem_rdata = 16'hDEAD; redirect = 1'b1; redirect_pc = 16'h000F;
      tick();
      redirect = 1'b0;
      checks++; if ({imem_addr, if_id_valid} !== {16'h000E, 1'b0})
         begin errors++; $display("FAIL sh_redir: got %h/%b want 000E/0", imem_addr, if_id_valid); end
      imem_rdata = 16'h5555;
      tick();
      checks++; if ({if_id_instr, if_id_next_pc, if_id_valid} !== {16'h5555, 16'h0010, 1'b1})
         begin errors++; $display("FAIL sh_pre: got %h/%h/%b want 5555/0010/1", if_id_instr, if_id_next_pc, if_id_valid); end
      stall = 1'b1; imem_rdata = 16'h7777;
      tick();
      imem_ready = 1'b0; imem_rdata = 16'hBAD1;
      for (int i = 0; i < 4; i++) begin
         checks++; if ({if_id_instr, if_id_next_pc, if_id_valid} !== {16'h5555, 16'h0010, 1'b1})
            begin errors++; $display("FAIL sh_hold_ifid%0d: got %h/%h/%b want 5555/0010/1", i, if_id_instr, if_id_next_pc, if_id_valid); end
         checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL sh_hold_req%0d: got %b want 0", i, imem_req); end
         if (i < 3) tick();
      end
      stall = 1'b0;
      tick();
      checks++; if ({if_id_instr, if_id_next_pc, if_id_valid} !== {16'h7777, 16'h0012, 1'b1})
         begin errors++; $display("FAIL sh_release: got %h/%h/%b want 7777/0012/1", if_id_instr, if_id_next_pc, if_id_valid); end
      checks++; if ({imem_req, imem_addr} !== {1'b1, 16'h0012})
         begin errors++; $display("FAIL sh_next_req: got %b/%h want 1/0012", imem_req, imem_addr); end
      imem_ready = 1'b1; imem_rdata = 16'h8888;
      tick();
      checks++; if ({if_id_instr, if_id_next_pc, if_id_valid} !== {16'h8888, 16'h0014, 1'b1})
         begin errors++; $display("FAIL sh_after: got %h/%h/%b want 8888/0014/1", if_id_instr, if_id_next_pc, if_id_valid); end
   endtask

   task automatic test_redirect_drain();
      do_reset();
      imem_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'h001E;
      tick();
      redirect = 1'b0; imem_rdata = 16'h9999;
      tick();
      checks++; if ({if_id_instr, if_id_next_pc, if_id_valid} !== {16'h9999, 16'h0020, 1'b1})
         begin errors++; $display("FAIL rd_pre: got %h/%h/%b want 9999/0020/1", if_id_instr, if_id_next_pc, if_id_valid); end
      imem_ready = 1'b0; stall = 1'b1;
      tick();
      checks++; if ({if_id_instr, if_id_valid} !== {16'h9999, 1'b1})
         begin errors++; $display("FAIL rd_stall_keep: got %h/%b want 9999/1", if_id_instr, if_id_valid); end
      redirect = 1'b1; redirect_pc = 16'h0040;
      tick();
      redirect = 1'b0; stall = 1'b0;
      checks++; if ({if_id_instr, if_id_valid} !== {16'h0000, 1'b0})
         begin errors++; $display("FAIL rd_flush: got %h/%b want 0000/0", if_id_instr, if_id_valid); end
      checks++; if ({imem_req, imem_addr} !== {1'b1, 16'h0020})
         begin errors++; $display("FAIL rd_drain_addr: got %b/%h want 1/0020", imem_req, imem_addr); end
      tick();
      checks++; if ({imem_req, imem_addr} !== {1'b1, 16'h0020})
         begin errors++; $display("FAIL rd_drain_wait: got %b/%h want 1/0020", imem_req, imem_addr); end
      imem_ready = 1'b1; imem_rdata = 16'hDEAD;
      tick();
      checks++; if ({if_id_instr, if_id_valid, imem_addr} !== {16'h0000, 1'b0, 16'h0040})
         begin errors++; $display("FAIL rd_discard: got %h/%b/%h want 0000/0/0040", if_id_instr, if_id_valid, imem_addr); end
      imem_rdata = 16'h4444;
      tick();
      checks++; if ({if_id_instr, if_id_next_pc, if_id_valid} !== {16'h4444, 16'h0042, 1'b1})
         begin errors++; $display("FAIL rd_target: got %h/%h/%b want 4444/0042/1", if_id_instr, if_id_next_pc, if_id_valid); end
   endtask

   task automatic test_halt();
      do_reset();
      imem_ready = 1'b1; imem_rdata = 16'hF000;
      tick();
      checks++; if ({if_id_instr, if_id_next_pc, if_id_valid} !== {16'hF000, 16'h0002, 1'b1})
         begin errors++; $display("FAIL ht_ifid: got %h/%h/%b want F000/0002/1", if_id_instr, if_id_next_pc, if_id_valid); end
      checks++; if ({halted, imem_req} !== 2'b10)
         begin errors++; $display("FAIL ht_state: got halted=%b req=%b want 1/0", halted, imem_req); end
      imem_rdata = 16'h1111;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if ({halted, imem_req, if_id_valid} !== 3'b100)
            begin errors++; $display("FAIL ht_idle%0d: got halted=%b req=%b valid=%b want 1/0/0", i, halted, imem_req, if_id_valid); end
      end
      redirect = 1'b1; redirect_pc = 16'h0100;
      tick();
      redirect = 1'b0;
      checks++; if ({halted, imem_req, imem_addr} !== {1'b0, 1'b1, 16'h0100})
         begin errors++; $display("FAIL ht_resume: got halted=%b req=%b addr=%h want 0/1/0100", halted, imem_req, imem_addr); end
      imem_rdata = 16'h1357;
      tick();
      checks++; if ({if_id_instr, if_id_next_pc, if_id_valid} !== {16'h1357, 16'h0102, 1'b1})
         begin errors++; $display("FAIL ht_first: got %h/%h/%b want 1357/0102/1", if_id_instr, if_id_next_pc, if_id_valid); end
   endtask

   task automatic test_wrap_and_async_reset();
      do_reset();
      imem_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'hFFFE;
      tick();
      redirect = 1'b0; imem_rdata = 16'h2468;
      tick();
      checks++; if ({if_id_instr, if_id_next_pc, if_id_valid} !== {16'h2468, 16'h0000, 1'b1})
         begin errors++; $display("FAIL wr_ifid: got %h/%h/%b want 2468/0000/1", if_id_instr, if_id_next_pc, if_id_valid); end
      checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL wr_addr: got %h want 0000", imem_addr); end
      imem_rdata = 16'h1111;
      tick();
      imem_ready = 1'b0;
      tick();
      checks++; if ({imem_req, imem_addr, if_id_instr} !== {1'b1, 16'h0002, 16'h0000})
         begin errors++; $display("FAIL wr_pending: got %b/%h/%h want 1/0002/0000", imem_req, imem_addr, if_id_instr); end
      stall = 1'b1;
      imem_ready = 1'b1; imem_rdata = 16'hF00D;
      tick();
      imem_ready = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      checks++; if ({imem_req, imem_addr, if_id_instr, if_id_next_pc, if_id_valid, halted} !== {1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0})
         begin errors++; $display("FAIL wr_async_rst: got req=%b addr=%h ifid=%h/%h/%b halted=%b", imem_req, imem_addr, if_id_instr, if_id_next_pc, if_id_valid, halted); end
      stall = 1'b0;
      rst = 1'b0;
      #1;
      checks++; if ({imem_req, imem_addr} !== {1'b1, 16'h0000})
         begin errors++; $display("FAIL wr_after_rst: got %b/%h want 1/0000", imem_req, imem_addr); end
   endtask

   initial begin
      test_reset();
      test_single_cycle();
      test_latency();
      test_stall_hold();
      test_redirect_drain();
      test_halt();
      test_wrap_and_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
